// File: rtl/onehot_grant_decoder_if.sv
// -----------------------------------------------------------------------------
// onehot_grant_decoder_if
//
// Purpose: bundles the code handshake, the per-line acknowledge bus and the
// grant/status outputs of onehot_grant_decoder.
//
// Signals:
//   in_code   [3:0]  encoded line index from the upstream priority encoder
//   in_valid         in_code is valid
//   in_ready         decoder can accept a code (high only when idle)
//   ack      [15:0]  per-line acknowledge from the requesters
//   grant    [15:0]  registered one-hot grant to the requesters
//   done             one-cycle pulse, grant acknowledged
//   stray_ack        one-cycle pulse, non-granted ack seen while granting
//   timeout          one-cycle pulse, grant abandoned (0 when timeout not built)
//   cur_code  [3:0]  code of the current/last grant
//
// Modports:
//   master - upstream producer / requesters (drives code, valid, ack)
//   slave  - the decoder itself
// -----------------------------------------------------------------------------
interface onehot_grant_decoder_if;
    logic [3:0]  in_code;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] ack;
    logic [15:0] grant;
    logic        done;
    logic        stray_ack;
    logic        timeout;
    logic [3:0]  cur_code;

    modport master (
        output in_code,
        output in_valid,
        output ack,
        input  in_ready,
        input  grant,
        input  done,
        input  stray_ack,
        input  timeout,
        input  cur_code
    );

    modport slave (
        input  in_code,
        input  in_valid,
        input  ack,
        output in_ready,
        output grant,
        output done,
        output stray_ack,
        output timeout,
        output cur_code
    );
endinterface

// File: rtl/onehot_grant_decoder.sv
// -----------------------------------------------------------------------------
// onehot_grant_decoder
//
// Purpose: takes a 4-bit line code from the 16:4 priority encoder through a
// ready/valid handshake, drives the matching one-hot grant line and holds it
// until the addressed requester completes a four-phase req/ack exchange
// (ack rises -> grant drops -> ack falls -> ready for the next code).
//
// Ports:
//   clk    input   rising-edge clock
//   rst_n  input   synchronous active-low reset
//   bus    slave   onehot_grant_decoder_if (code handshake, ack, grant, status)
//
// Parameters:
//   TIMEOUT  (1..255, default 255) GRANT cycles without ack before the grant
//            is abandoned. Only meaningful with GRANT_TIMEOUT_EN.
//
// Build option:
//   GRANT_TIMEOUT_EN - when defined, an 8-bit counter abandons an
//   unacknowledged grant after TIMEOUT cycles and pulses timeout. When not
//   defined, no counter exists, timeout is tied low and GRANT waits forever.
// -----------------------------------------------------------------------------
module onehot_grant_decoder #(
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    onehot_grant_decoder_if.slave  bus
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    // An 8-bit counter cannot reach anything outside 1..255.
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("onehot_grant_decoder: TIMEOUT must be in 1..255");
    end

    logic [1:0]  r_state;
    logic [15:0] r_grant;
    logic        r_done;
    logic        r_stray;
    logic [3:0]  r_code;

    logic [15:0] w_dec_in;    // one-hot decode of the incoming code
    logic [15:0] w_own_mask;  // one-hot mask of the latched code
    logic        w_ack_hit;
    logic        w_ack_stray;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_dec
            assign w_dec_in[gi]   = (bus.in_code == 4'(gi));
            assign w_own_mask[gi] = (r_code == 4'(gi));
        end
    endgenerate

    assign w_ack_hit   = |(bus.ack & w_own_mask);
    // Stray is judged independently of the hit: both may fire together.
    assign w_ack_stray = |(bus.ack & ~w_own_mask);

`ifdef GRANT_TIMEOUT_EN
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [7:0] r_cnt;
    logic       r_timeout;
    logic       w_expire;

    // r_cnt is 0 in the first GRANT cycle, so the grant is visible for
    // exactly TIMEOUT cycles before the abandoning edge.
    assign w_expire = (r_cnt == CNT_LAST);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_grant <= 16'h0000;
            r_done  <= 1'b0;
            r_stray <= 1'b0;
            r_code  <= 4'h0;
`ifdef GRANT_TIMEOUT_EN
            r_cnt     <= 8'h00;
            r_timeout <= 1'b0;
`endif
        end else begin
            // Status outputs are single-cycle pulses unless re-asserted.
            r_done  <= 1'b0;
            r_stray <= 1'b0;
`ifdef GRANT_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    // ack is deliberately not looked at here.
                    r_grant <= 16'h0000;
                    if (bus.in_valid) begin
                        r_code  <= bus.in_code;
                        r_grant <= w_dec_in;
                        r_state <= ST_GRANT;
`ifdef GRANT_TIMEOUT_EN
                        r_cnt   <= 8'h00;
`endif
                    end
                end

                ST_GRANT: begin
                    r_stray <= w_ack_stray;
                    // An ack on the expiry edge wins over the timeout.
                    if (w_ack_hit) begin
                        r_grant <= 16'h0000;
                        r_done  <= 1'b1;
                        r_state <= ST_RELEASE;
                    end
`ifdef GRANT_TIMEOUT_EN
                    else if (w_expire) begin
                        // Abandoned grants skip RELEASE: no ack to wait out.
                        r_grant   <= 16'h0000;
                        r_timeout <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'h01;
                    end
`endif
                end

                ST_RELEASE: begin
                    // Wait for the requester to drop its ack before
                    // accepting another code.
                    r_grant <= 16'h0000;
                    if (!w_ack_hit) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_grant <= 16'h0000;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.grant     = r_grant;
    assign bus.done      = r_done;
    assign bus.stray_ack = r_stray;
    assign bus.cur_code  = r_code;
`ifdef GRANT_TIMEOUT_EN
    assign bus.timeout   = r_timeout;
`else
    assign bus.timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_onehot_grant_decoder.sv
// -----------------------------------------------------------------------------
// tb_onehot_grant_decoder
//
// Directed bench for onehot_grant_decoder. Inputs are driven 1 ns after the
// rising edge and outputs are sampled at the same point. With
// GRANT_TIMEOUT_EN defined the DUT is built with TIMEOUT=8.
// -----------------------------------------------------------------------------
module tb_onehot_grant_decoder;

`ifdef GRANT_TIMEOUT_EN
    localparam int TO_CYCLES = 8;
`else
    localparam int TO_CYCLES = 255;
`endif

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_vec;
    int   n_err;

    onehot_grant_decoder_if bus ();

    onehot_grant_decoder #(
        .TIMEOUT (TO_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        n_vec = n_vec + 1;
        if (obs !== exp_val) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_val, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for in_ready; an expired bound shows up as a failed check.
    task automatic wait_ready(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (bus.in_ready === 1'b1) break;
            tick();
        end
        check(tag, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic handshake(input logic [3:0] code);
        bus.in_code  = code;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    int          hs_prev;
    logic [3:0]  b2b_codes [3];
    logic [15:0] b2b_grant [3];

    initial begin
        n_vec = 0;
        n_err = 0;
        b2b_codes[0] = 4'd14; b2b_grant[0] = 16'h4000;
        b2b_codes[1] = 4'd12; b2b_grant[1] = 16'h1000;
        b2b_codes[2] = 4'd7;  b2b_grant[2] = 16'h0080;

        rst_n        = 1'b0;
        bus.in_code  = 4'h0;
        bus.in_valid = 1'b0;
        bus.ack      = 16'h0000;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        check("rst_grant",    32'(bus.grant),     32'h0);
        check("rst_done",     32'(bus.done),      32'h0);
        check("rst_stray",    32'(bus.stray_ack), 32'h0);
        check("rst_timeout",  32'(bus.timeout),   32'h0);
        check("rst_cur_code", 32'(bus.cur_code),  32'h0);
        check("rst_ready",    32'(bus.in_ready),  32'h1);

        // Ack during the idle handshake cycle is ignored; reset mid-grant
        bus.ack = 16'h0020;
        handshake(4'd5);
        bus.ack = 16'h0000;
        check("mid_grant",    32'(bus.grant),    32'h0020);
        check("mid_ready",    32'(bus.in_ready), 32'h0);
        check("mid_cur_code", 32'(bus.cur_code), 32'h5);
        check("mid_done",     32'(bus.done),     32'h0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mrst_grant",    32'(bus.grant),    32'h0);
        check("mrst_ready",    32'(bus.in_ready), 32'h1);
        check("mrst_cur_code", 32'(bus.cur_code), 32'h0);

        // Single grant, code 0
        handshake(4'd0);
        check("c0_grant", 32'(bus.grant), 32'h0001);
        bus.ack = 16'h0001;
        tick();
        bus.ack = 16'h0000;
        check("c0_done",  32'(bus.done),     32'h1);
        check("c0_gclr",  32'(bus.grant),    32'h0);
        check("c0_rel",   32'(bus.in_ready), 32'h0);
        tick();
        check("c0_done1", 32'(bus.done),     32'h0);
        check("c0_ready", 32'(bus.in_ready), 32'h1);

        // Top line with ack held 5 cycles
        handshake(4'd15);
        check("c15_grant", 32'(bus.grant), 32'h8000);
        bus.ack = 16'h8000;
        tick();
        check("c15_done", 32'(bus.done),  32'h1);
        check("c15_gclr", 32'(bus.grant), 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("c15_hold_ready", 32'(bus.in_ready), 32'h0);
            check("c15_hold_done",  32'(bus.done),     32'h0);
        end
        bus.ack = 16'h0000;
        tick();
        check("c15_ready", 32'(bus.in_ready), 32'h1);

        // Stray ack while granting code 13
        handshake(4'd13);
        check("c13_grant", 32'(bus.grant), 32'h2000);
        bus.ack = 16'h0080;
        tick();
        check("c13_stray", 32'(bus.stray_ack), 32'h1);
        check("c13_held",  32'(bus.grant),     32'h2000);
        check("c13_nodone",32'(bus.done),      32'h0);
        bus.ack = 16'h2000;
        tick();
        bus.ack = 16'h0000;
        check("c13_done",   32'(bus.done),      32'h1);
        check("c13_stray0", 32'(bus.stray_ack), 32'h0);
        check("c13_gclr",   32'(bus.grant),     32'h0);
        tick();
        check("c13_ready", 32'(bus.in_ready), 32'h1);

        // Hit and stray on the same edge; stray in RELEASE is ignored
        handshake(4'd2);
        check("c2_grant", 32'(bus.grant), 32'h0004);
        bus.ack = 16'h0104;
        tick();
        check("c2_done",  32'(bus.done),      32'h1);
        check("c2_stray", 32'(bus.stray_ack), 32'h1);
        bus.ack = 16'h8004;
        tick();
        check("c2_rel_stray", 32'(bus.stray_ack), 32'h0);
        check("c2_rel_ready", 32'(bus.in_ready),  32'h0);
        bus.ack = 16'h0000;
        tick();
        check("c2_ready", 32'(bus.in_ready), 32'h1);

        // Back-to-back: valid held, requester acks one cycle after seeing grant
        hs_prev = 0;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.in_code = b2b_codes[k];
            wait_ready("b2b_wait");
            tick();
            check("b2b_grant", 32'(bus.grant), 32'(b2b_grant[k]));
            if (k > 0) check("b2b_gap", 32'(cyc - hs_prev), 32'd4);
            hs_prev = cyc;
            tick();
            bus.ack = b2b_grant[k];
            tick();
            bus.ack = 16'h0000;
            check("b2b_done", 32'(bus.done), 32'h1);
            tick();
        end
        bus.in_valid = 1'b0;
        check("b2b_ready", 32'(bus.in_ready), 32'h1);

`ifdef GRANT_TIMEOUT_EN
        // Timeout after 8 unacknowledged GRANT cycles
        handshake(4'd3);
        for (int i = 0; i < 8; i++) begin
            check("to_grant",  32'(bus.grant),   32'h0008);
            check("to_nopulse",32'(bus.timeout), 32'h0);
            tick();
        end
        check("to_pulse", 32'(bus.timeout),  32'h1);
        check("to_gclr",  32'(bus.grant),    32'h0);
        check("to_ready", 32'(bus.in_ready), 32'h1);
        tick();
        check("to_pulse1", 32'(bus.timeout), 32'h0);

        // Ack on the expiry edge wins
        handshake(4'd4);
        for (int i = 0; i < 7; i++) tick();
        check("tp_grant", 32'(bus.grant), 32'h0010);
        bus.ack = 16'h0010;
        tick();
        bus.ack = 16'h0000;
        check("tp_done",    32'(bus.done),    32'h1);
        check("tp_timeout", 32'(bus.timeout), 32'h0);
        tick();
        check("tp_ready", 32'(bus.in_ready), 32'h1);
`else
        // Without the timeout option the grant is held indefinitely
        handshake(4'd3);
        for (int i = 0; i < 20; i++) begin
            check("nt_grant",   32'(bus.grant),   32'h0008);
            check("nt_timeout", 32'(bus.timeout), 32'h0);
            tick();
        end
        bus.ack = 16'h0008;
        tick();
        bus.ack = 16'h0000;
        check("nt_done", 32'(bus.done), 32'h1);
        tick();
        check("nt_ready", 32'(bus.in_ready), 32'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
